// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start/busy/done handshake
// plus operands, difference and flags.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bi,
        input  d, bo, overflow, zero, busy, done
    );

    modport slave (
        input  start, a, b, bi,
        output d, bo, overflow, zero, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B - Bi, one bit per clock, LSB first.
// Results and flags load together on the edge entering StDone and hold until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave sub_io
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bo_q, bo_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             bit_d, br_nxt;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        bit_d   = a_q[0] ^ b_q[0] ^ br_q;
        br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

        unique case (state_q)
            StIdle, StDone: begin
                // StDone lasts one cycle; a start seen there chains straight into StRun.
                if (sub_io.start) begin
                    state_d = StRun;
                    a_d     = sub_io.a;
                    b_d     = sub_io.b;
                    br_d    = sub_io.bi;
                    a_msb_d = sub_io.a[WIDTH-1];
                    b_msb_d = sub_io.b[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nxt;
                res_d = {bit_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    d_d     = res_d;
                    bo_d    = br_nxt;
                    ovf_d   = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                    zero_d  = (res_d == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign sub_io.d        = d_q;
    assign sub_io.bo       = bo_q;
    assign sub_io.overflow = ovf_q;
    assign sub_io.zero     = zero_q;
    assign sub_io.busy     = (state_q == StRun);
    assign sub_io.done     = (state_q == StDone);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor: computes D = A − B − Bi one bit per clock, LSB first.
- Inverse-direction companion to the team's 4-bit ripple adder.
- Reports the same style of flags: carry/borrow out, signed overflow and zero.
- Used where area matters more than latency; a start/busy/done handshake lets a controller sequence operations.

Parameters:
WIDTH, 4, operand and result width in bits (≥2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge when accepting
A  input  WIDTH  minuend, captured when start accepted
B  input  WIDTH  subtrahend, captured when start accepted
Bi  input  1  borrow in, captured when start accepted
D  output  WIDTH  registered difference
Bo  output  1  registered borrow out (1 when unsigned A < B+Bi)
overflow  output  1  registered signed overflow
zero  output  1  registered, 1 when D == 0
busy  output  1  high while subtraction in progress
done  output  1  one-cycle pulse, results valid

Behaviour:
- Reset (async, active-high): state IDLE; D=0, Bo=0, overflow=0, zero=0, busy=0, done=0; internal shift registers, borrow and bit counter cleared.
- FSM states:
  - IDLE: busy=0, done=0. On start=1 → RUN; latch A, B into shift registers, borrow ← Bi, counter ← 0.
  - RUN: busy=1. Each edge processes one bit, LSB first:
    - d = a ^ b ^ br
    - br' = (~a & b) | (~(a ^ b) & br)
    - shift d into result register; counter++.
    - After WIDTH bits → DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then → IDLE. If start=1 in DONE, a new operation is accepted (→ RUN, latch) instead of → IDLE.
- Output update: on the edge entering DONE, D, Bo, overflow and zero load together, then hold until the next completion. No partial results ever appear on D.
  - Bo = final borrow.
  - overflow = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), using the latched A and B.
  - zero = (D == 0).
- Latency: start sampled at edge 0. Edges 1..WIDTH process bits. done is high between edge WIDTH and WIDTH+1; busy is high between edge 0 and edge WIDTH.
- start while in RUN is ignored; operand changes during RUN have no effect.
- Reset mid-operation aborts immediately: no done pulse, outputs return to reset values.
- Arithmetic is modulo 2^WIDTH. Bi=1 subtracts an additional 1, including the wrap from 0.

Test Plan:
- A=7, B=3, Bi=0, start at edge 0 → done at edge 4 (WIDTH=4); D=4, Bo=0, overflow=0, zero=0; busy high for edges 0–4 only.
- A=3, B=5, Bi=0 → D=4'b1110, Bo=1, overflow=0, zero=0.
- A=4'b0101, B=4'b1100 (5 − (−4)) → D=4'b1001, overflow=1, Bo=1.
- A=4, B=4, Bi=0 → D=0, zero=1, Bo=0. Then A=4, B=4, Bi=1 → D=4'b1111, Bo=1, zero=0, overflow=0.
- start re-asserted with new operands at edge 2 during RUN → ignored; result matches the original operands. start held high in the DONE cycle → second operation begins immediately; its done arrives 4 edges later.
- rst pulsed asynchronously between edges 2 and 3 of an operation → busy=0 immediately, no done pulse, D/Bo/overflow/zero=0. The next start completes normally.
